// File: rtl/terminal_fifo_bank_if.sv
// terminal_fifo_bank_if: host/bus-side signal bundle of the per-terminal FIFO bank.
// Every signal is indexed [bus][terminal]; data signals add a [width] dimension.
// The master modport is the host/bus agent side, the slave modport is the FIFO bank.
interface terminal_fifo_bank_if #(
    parameter int bits    = 1,
    parameter int drivers = 4,
    parameter int width   = 32
);
    // host side of the TX FIFO
    logic [bits-1:0][drivers-1:0]             wr_i;
    logic [bits-1:0][drivers-1:0][width-1:0]  wr_data_i;
    logic [bits-1:0][drivers-1:0]             tx_full_o;
    // bus side of the TX FIFO
    logic [bits-1:0][drivers-1:0]             pndng_o;
    logic [bits-1:0][drivers-1:0][width-1:0]  d_pop_o;
    logic [bits-1:0][drivers-1:0]             pop_i;
    // bus side of the RX FIFO
    logic [bits-1:0][drivers-1:0]             push_i;
    logic [bits-1:0][drivers-1:0][width-1:0]  d_push_i;
    // host side of the RX FIFO
    logic [bits-1:0][drivers-1:0]             rd_i;
    logic [bits-1:0][drivers-1:0]             rx_vld_o;
    logic [bits-1:0][drivers-1:0][width-1:0]  rd_data_o;
    // sticky per-terminal error flags
    logic [bits-1:0][drivers-1:0]             ovf_o;
    logic [bits-1:0][drivers-1:0]             udf_o;

    modport master (
        output wr_i, wr_data_i, pop_i, push_i, d_push_i, rd_i,
        input  tx_full_o, pndng_o, d_pop_o, rx_vld_o, rd_data_o, ovf_o, udf_o
    );

    modport slave (
        input  wr_i, wr_data_i, pop_i, push_i, d_push_i, rd_i,
        output tx_full_o, pndng_o, d_pop_o, rx_vld_o, rd_data_o, ovf_o, udf_o
    );
endinterface

// File: rtl/terminal_fifo_bank.sv
// terminal_fifo_bank: one TX FIFO (host writes, bus pops) and one RX FIFO
// (bus pushes, host reads) per terminal, per bus. Heads are first-word-fall-through
// and read as zero while the FIFO is empty. ovf/udf are sticky per terminal and
// shared by its TX and RX sides.
// Optional feature macro: TFB_DEST_FILTER_EN -- when defined, an RX push is kept
// only if its destination id (top 8 bits) equals the terminal index or broadcast;
// a filtered push is dropped silently without raising ovf.

// Single circular-buffer FIFO with drop/underflow event outputs.
module terminal_fifo_bank_fifo #(
    parameter int width = 32,
    parameter int depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr,
    input  logic [width-1:0] wr_data,
    input  logic             rd,
    output logic [width-1:0] rd_data,
    output logic             vld,
    output logic             full,
    output logic             ovf_evt,
    output logic             udf_evt
);
    localparam int aw = $clog2(depth);

    logic [width-1:0] mem_r [depth];
    logic [aw-1:0]    wptr_r;
    logic [aw-1:0]    rptr_r;
    logic [aw:0]      count_r;
    logic [aw-1:0]    wptr_nxt_s;
    logic [aw-1:0]    rptr_nxt_s;
    logic [aw:0]      count_nxt_s;
    logic             full_s;
    logic             empty_s;
    logic             wr_acc_s;
    logic             rd_acc_s;

    // Occupancy decode and accept rules: a write into a full FIFO is still
    // taken when the same cycle frees a slot with an accepted read.
    always_comb begin
        full_s   = (count_r == (aw+1)'(depth));
        empty_s  = (count_r == (aw+1)'(1'b0));
        rd_acc_s = rd & ~empty_s;
        wr_acc_s = wr & (~full_s | rd);
    end

    // Next pointer/count values; count moves only when exactly one side is accepted.
    always_comb begin
        wptr_nxt_s  = wptr_r;
        rptr_nxt_s  = rptr_r;
        count_nxt_s = count_r;
        if (wr_acc_s) begin
            wptr_nxt_s = wptr_r + aw'(1'b1);
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (rd_acc_s) begin
            rptr_nxt_s = rptr_r + aw'(1'b1);
        end else begin
            rptr_nxt_s = rptr_r;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + (aw+1)'(1'b1);
            2'b01:   count_nxt_s = count_r - (aw+1)'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_r  <= aw'(1'b0);
            rptr_r  <= aw'(1'b0);
            count_r <= (aw+1)'(1'b0);
        end else begin
            wptr_r  <= wptr_nxt_s;
            rptr_r  <= rptr_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_acc_s) begin
            mem_r[wptr_r] <= wr_data;
        end
    end

    // When full, wptr equals rptr, so a write+read in that cycle overwrites the
    // slot whose old value is the one being popped this same cycle.
    assign rd_data = empty_s ? {width{1'b0}} : mem_r[rptr_r];
    assign vld     = ~empty_s;
    assign full    = full_s;
    assign ovf_evt = wr & ~wr_acc_s;
    assign udf_evt = rd & empty_s;
endmodule

// Bank of per-terminal TX/RX FIFO pairs with sticky error flags.
module terminal_fifo_bank #(
    parameter int         bits      = 1,
    parameter int         drivers   = 4,
    parameter int         width     = 32,
    parameter int         depth     = 8,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_err_i,
    terminal_fifo_bank_if.slave  fb
);
    for (genvar b = 0; b < bits; b++) begin : g_bus
        for (genvar d = 0; d < drivers; d++) begin : g_term
            logic push_ok_s;
            logic dest_ok_s;
            logic tx_ovf_s;
            logic tx_udf_s;
            logic rx_ovf_s;
            logic rx_udf_s;
            logic unused_rx_full_s;
            logic ovf_r;
            logic udf_r;

            assign dest_ok_s = (fb.d_push_i[b][d][width-1 -: 8] == 8'(d)) ||
                               (fb.d_push_i[b][d][width-1 -: 8] == broadcast);

`ifdef TFB_DEST_FILTER_EN
            // A push addressed elsewhere never reaches the FIFO, so it cannot overflow.
            assign push_ok_s = fb.push_i[b][d] & dest_ok_s;
`else
            logic unused_dest_s;
            assign unused_dest_s = dest_ok_s;
            assign push_ok_s     = fb.push_i[b][d];
`endif

            terminal_fifo_bank_fifo #(
                .width (width),
                .depth (depth)
            ) u_tx (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .wr      (fb.wr_i[b][d]),
                .wr_data (fb.wr_data_i[b][d]),
                .rd      (fb.pop_i[b][d]),
                .rd_data (fb.d_pop_o[b][d]),
                .vld     (fb.pndng_o[b][d]),
                .full    (fb.tx_full_o[b][d]),
                .ovf_evt (tx_ovf_s),
                .udf_evt (tx_udf_s)
            );

            terminal_fifo_bank_fifo #(
                .width (width),
                .depth (depth)
            ) u_rx (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .wr      (push_ok_s),
                .wr_data (fb.d_push_i[b][d]),
                .rd      (fb.rd_i[b][d]),
                .rd_data (fb.rd_data_o[b][d]),
                .vld     (fb.rx_vld_o[b][d]),
                .full    (unused_rx_full_s),
                .ovf_evt (rx_ovf_s),
                .udf_evt (rx_udf_s)
            );

            // Sticky error flags; a new event in the clear cycle keeps the flag set.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    ovf_r <= 1'b0;
                    udf_r <= 1'b0;
                end else begin
                    ovf_r <= (ovf_r & ~clr_err_i) | tx_ovf_s | rx_ovf_s;
                    udf_r <= (udf_r & ~clr_err_i) | tx_udf_s | rx_udf_s;
                end
            end

            assign fb.ovf_o[b][d] = ovf_r;
            assign fb.udf_o[b][d] = udf_r;
        end
    end
endmodule

// File: tb/tb_terminal_fifo_bank.sv
// Self-checking bench for terminal_fifo_bank (1 bus, 4 terminals, 32-bit, depth 8).
// Reference model: one queue per FIFO plus per-terminal sticky flags.
module tb_terminal_fifo_bank;
    localparam int W   = 32;
    localparam int D   = 4;
    localparam int DEP = 8;

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic clr_err_i;

    always #5 clk_i = ~clk_i;

    terminal_fifo_bank_if #(.bits(1), .drivers(D), .width(W)) fb ();

    terminal_fifo_bank #(
        .bits(1), .drivers(D), .width(W), .depth(DEP), .broadcast(8'hFF)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_err_i (clr_err_i),
        .fb        (fb)
    );

    logic [W-1:0] tx_q [D][$];
    logic [W-1:0] rx_q [D][$];
    bit           ovf_m [D];
    bit           udf_m [D];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        fb.wr_i      = '0;
        fb.wr_data_i = '0;
        fb.pop_i     = '0;
        fb.push_i    = '0;
        fb.d_push_i  = '0;
        fb.rd_i      = '0;
        clr_err_i    = 1'b0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < D; d++) begin
            tx_q[d].delete();
            rx_q[d].delete();
            ovf_m[d] = 1'b0;
            udf_m[d] = 1'b0;
        end
    endtask

    // Applies the currently driven inputs to the queue model (one clock edge).
    task automatic model_step();
        for (int d = 0; d < D; d++) begin
            bit           wr, pop, psh, rd, twa, tpa, rwa, rpa;
            int           ts, rs;
            logic [W-1:0] wd, pd;
            wr  = fb.wr_i[0][d];
            pop = fb.pop_i[0][d];
            psh = fb.push_i[0][d];
            rd  = fb.rd_i[0][d];
            wd  = fb.wr_data_i[0][d];
            pd  = fb.d_push_i[0][d];
`ifdef TFB_DEST_FILTER_EN
            psh = psh && ((pd[31:24] == 8'(d)) || (pd[31:24] == 8'hFF));
`endif
            ts  = tx_q[d].size();
            rs  = rx_q[d].size();
            tpa = pop && (ts > 0);
            twa = wr && ((ts < DEP) || pop);
            rpa = rd && (rs > 0);
            rwa = psh && ((rs < DEP) || rd);
            ovf_m[d] = (ovf_m[d] && !clr_err_i) || (wr && !twa) || (psh && !rwa);
            udf_m[d] = (udf_m[d] && !clr_err_i) || (pop && ts == 0) || (rd && rs == 0);
            if (tpa) void'(tx_q[d].pop_front());
            if (twa) tx_q[d].push_back(wd);
            if (rpa) void'(rx_q[d].pop_front());
            if (rwa) rx_q[d].push_back(pd);
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < D; d++) begin
            chk($sformatf("%s pndng[%0d]", tag, d), W'(fb.pndng_o[0][d]), W'(tx_q[d].size() > 0));
            chk($sformatf("%s tx_full[%0d]", tag, d), W'(fb.tx_full_o[0][d]), W'(tx_q[d].size() == DEP));
            chk($sformatf("%s d_pop[%0d]", tag, d), fb.d_pop_o[0][d],
                (tx_q[d].size() > 0) ? tx_q[d][0] : 32'h0);
            chk($sformatf("%s rx_vld[%0d]", tag, d), W'(fb.rx_vld_o[0][d]), W'(rx_q[d].size() > 0));
            chk($sformatf("%s rd_data[%0d]", tag, d), fb.rd_data_o[0][d],
                (rx_q[d].size() > 0) ? rx_q[d][0] : 32'h0);
            chk($sformatf("%s ovf[%0d]", tag, d), W'(fb.ovf_o[0][d]), W'(ovf_m[d]));
            chk($sformatf("%s udf[%0d]", tag, d), W'(fb.udf_o[0][d]), W'(udf_m[d]));
        end
    endtask

    // One clock: model update, edge, check 1 time unit later, then idle inputs.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk_i);
        #1;
        check_all(tag);
        idle();
    endtask

    initial begin
        rst_n_i = 1'b0;
        idle();
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_all("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Single write then pop on terminal 0.
        fb.wr_i[0][0] = 1'b1;
        fb.wr_data_i[0][0] = 32'h0100_00AA;
        cycle("t1_wr");
        chk("t1_pndng", W'(fb.pndng_o[0][0]), 32'd1);
        chk("t1_dpop", fb.d_pop_o[0][0], 32'h0100_00AA);
        fb.pop_i[0][0] = 1'b1;
        cycle("t1_pop");
        chk("t1_pndng_low", W'(fb.pndng_o[0][0]), 32'd0);
        chk("t1_udf", W'(fb.udf_o[0][0]), 32'd0);

        // Fill TX[1], overflow, drain in order, clear error.
        for (int i = 1; i <= DEP; i++) begin
            fb.wr_i[0][1] = 1'b1;
            fb.wr_data_i[0][1] = W'(i);
            cycle("t2_fill");
        end
        chk("t2_full", W'(fb.tx_full_o[0][1]), 32'd1);
        fb.wr_i[0][1] = 1'b1;
        fb.wr_data_i[0][1] = 32'h0000_0099;
        cycle("t2_drop");
        chk("t2_ovf", W'(fb.ovf_o[0][1]), 32'd1);
        for (int i = 1; i <= DEP; i++) begin
            chk("t2_order", fb.d_pop_o[0][1], W'(i));
            fb.pop_i[0][1] = 1'b1;
            cycle("t2_pop");
        end
        clr_err_i = 1'b1;
        cycle("t2_clr");
        chk("t2_ovf_clr", W'(fb.ovf_o[0][1]), 32'd0);

        // Full FIFO with simultaneous write and pop, then underflow.
        for (int i = 1; i <= DEP; i++) begin
            fb.wr_i[0][1] = 1'b1;
            fb.wr_data_i[0][1] = W'(i);
            cycle("t3_fill");
        end
        chk("t3_head", fb.d_pop_o[0][1], 32'd1);
        fb.wr_i[0][1] = 1'b1;
        fb.wr_data_i[0][1] = 32'd9;
        fb.pop_i[0][1] = 1'b1;
        cycle("t3_both");
        chk("t3_still_full", W'(fb.tx_full_o[0][1]), 32'd1);
        chk("t3_no_ovf", W'(fb.ovf_o[0][1]), 32'd0);
        for (int i = 2; i <= DEP + 1; i++) begin
            chk("t3_order", fb.d_pop_o[0][1], W'(i));
            fb.pop_i[0][1] = 1'b1;
            cycle("t3_pop");
        end
        fb.pop_i[0][1] = 1'b1;
        cycle("t3_udf");
        chk("t3_udf_set", W'(fb.udf_o[0][1]), 32'd1);
        fb.wr_i[0][1] = 1'b1;
        fb.wr_data_i[0][1] = 32'h0000_0077;
        clr_err_i = 1'b1;
        cycle("t3_after_udf");
        chk("t3_ptr_ok", fb.d_pop_o[0][1], 32'h0000_0077);
        fb.pop_i[0][1] = 1'b1;
        cycle("t3_drain");

        // RX[2] push/read, then overflow on full.
        fb.push_i[0][2] = 1'b1;
        fb.d_push_i[0][2] = 32'h0200_0005;
        cycle("t4_push");
        chk("t4_vld", W'(fb.rx_vld_o[0][2]), 32'd1);
        chk("t4_data", fb.rd_data_o[0][2], 32'h0200_0005);
        fb.rd_i[0][2] = 1'b1;
        cycle("t4_rd");
        chk("t4_vld_low", W'(fb.rx_vld_o[0][2]), 32'd0);
        for (int i = 0; i < DEP; i++) begin
            fb.push_i[0][2] = 1'b1;
            fb.d_push_i[0][2] = 32'h0200_0000 | W'(i);
            cycle("t4_fill");
        end
        fb.push_i[0][2] = 1'b1;
        fb.d_push_i[0][2] = 32'h0200_00EE;
        cycle("t4_ovf");
        chk("t4_ovf_set", W'(fb.ovf_o[0][2]), 32'd1);
        for (int i = 0; i < DEP; i++) begin
            fb.rd_i[0][2] = 1'b1;
            cycle("t4_drain");
        end
        clr_err_i = 1'b1;
        cycle("t4_clr");

        // Destination filtering on terminal 2.
        fb.push_i[0][2] = 1'b1;
        fb.d_push_i[0][2] = 32'h0300_0001;
        cycle("t5_other");
`ifdef TFB_DEST_FILTER_EN
        chk("t5_discard", W'(fb.rx_vld_o[0][2]), 32'd0);
        chk("t5_no_ovf", W'(fb.ovf_o[0][2]), 32'd0);
`else
        chk("t5_accept_any", fb.rd_data_o[0][2], 32'h0300_0001);
`endif
        fb.push_i[0][2] = 1'b1;
        fb.d_push_i[0][2] = 32'hFF00_0001;
        cycle("t5_bcast");
        chk("t5_bcast_vld", W'(fb.rx_vld_o[0][2]), 32'd1);
        for (int k = 0; k < DEP && rx_q[2].size() > 0; k++) begin
            fb.rd_i[0][2] = 1'b1;
            cycle("t5_drain");
        end

        // Randomized traffic: write-heavy half, then read-heavy half.
        for (int n = 0; n < 400; n++) begin
            int wp, rp;
            wp = (n < 200) ? 60 : 30;
            rp = (n < 200) ? 30 : 60;
            for (int d = 0; d < D; d++) begin
                logic [W-1:0] pd;
                fb.wr_i[0][d]      = ($urandom_range(0, 99) < wp);
                fb.wr_data_i[0][d] = $urandom;
                fb.pop_i[0][d]     = ($urandom_range(0, 99) < rp);
                fb.push_i[0][d]    = ($urandom_range(0, 99) < wp);
                fb.rd_i[0][d]      = ($urandom_range(0, 99) < rp);
                pd = $urandom;
                case ($urandom_range(0, 2))
                    0:       pd[31:24] = 8'(d);
                    1:       pd[31:24] = 8'hFF;
                    default: pd[31:24] = pd[31:24];
                endcase
                fb.d_push_i[0][d] = pd;
            end
            clr_err_i = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end

        // Asynchronous reset mid-clock with entries queued.
        for (int k = 0; k < DEP + 1 && tx_q[0].size() > 0; k++) begin
            fb.pop_i[0][0] = 1'b1;
            cycle("t6_empty");
        end
        for (int i = 0; i < 3; i++) begin
            fb.wr_i[0][0] = 1'b1;
            fb.wr_data_i[0][0] = 32'h0600_0000 | W'(i);
            cycle("t6_fill");
        end
        chk("t6_pre_pndng", W'(fb.pndng_o[0][0]), 32'd1);
        #3;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        chk("t6_async_pndng", W'(fb.pndng_o[0][0]), 32'd0);
        check_all("t6_in_reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        fb.wr_i[0][0] = 1'b1;
        fb.wr_data_i[0][0] = 32'hABCD_0001;
        cycle("t6_new");
        chk("t6_new_data", fb.d_pop_o[0][0], 32'hABCD_0001);
        fb.pop_i[0][0] = 1'b1;
        cycle("t6_pop");
        chk("t6_only_new", W'(fb.pndng_o[0][0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
